pipe_ifetch_queue: RTL
======================

// Module: pipe_ifetch_queue
// PURPOSE
//   Instruction-fetch initiator for the pipelined CPU: owns the fetch PC, issues word
//   addresses to the instruction memory and buffers returned instructions with their PCs
//   in a small prefetch FIFO. Sits between the instruction memory (responder) and the
//   ID stage. Decouples ID stalls from memory timing and supports single-cycle branch
//   redirect with a full queue flush.
// PARAMETERS
//   RESET_PC   32'h0000_0000  fetch PC loaded on reset; bits [1:0] must be 0
//   DEPTH      4              prefetch FIFO entries; power of two, 2..16
// PORTS
//   clock        in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request valid this cycle
//   imem_addr    out  32  byte address of requested word (= fetch PC, [1:0]=0)
//   imem_ack     in   1   memory returns imem_inst for imem_addr this cycle
//   imem_inst    in   32  instruction word, valid when imem_req && imem_ack
//   redirect     in   1   branch/jump taken: flush queue, restart fetch
//   redirect_pc  in   32  new fetch PC; bits [1:0] ignored (forced 0)
//   if_valid     out  1   head of queue valid for ID
//   if_inst      out  32  head instruction
//   if_pc        out  32  PC of head instruction
//   id_ready     in   1   ID accepts head this cycle (not stalled)
//   q_count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   State: fetch_pc (32b), FIFO storage {pc,inst} x DEPTH, rd_ptr, wr_ptr, count.
//   Reset (clock edge with reset=1): fetch_pc<=RESET_PC, rd_ptr=wr_ptr=count<=0.
//     While reset=1: imem_req=0, if_valid=0. Storage contents not reset (don't care).
//   imem_req  = !reset && !redirect && (count != DEPTH). Full uses registered count only;
//     a same-cycle pop does not open a slot for a same-cycle push.
//   imem_addr = fetch_pc (combinational from register); stable while req && !ack.
//   Push = imem_req && imem_ack: write {fetch_pc, imem_inst} at wr_ptr, wr_ptr++,
//     fetch_pc <= fetch_pc + 4 (mod 2^32: 32'hFFFF_FFFC wraps to 0).
//   imem_ack while imem_req=0 is ignored (no push, no PC change).
//   if_valid = !reset && !redirect && (count != 0); if_inst/if_pc = entry at rd_ptr.
//   Pop = if_valid && id_ready: rd_ptr++. Pointers wrap modulo DEPTH.
//   count: push&&pop -> unchanged; push only -> +1; pop only -> -1.
//   Empty queue: no fall-through; an instruction pushed at edge N is visible at
//     if_valid after edge N (min fetch-to-ID latency 1 cycle).
//   Redirect (priority over everything except reset): at the edge, rd_ptr=wr_ptr=
//     count<=0, fetch_pc <= {redirect_pc[31:2],2'b00}. No push and no pop in that
//     cycle (both req and if_valid are low). Fetch resumes at new PC next cycle.
//   Redirect asserted on consecutive cycles: last one wins.
//   Reset asserted mid-operation: identical to power-on reset; pending data discarded.
//   id_ready with queue empty: no effect, count stays 0 (no underflow).
// TESTING
//   1 Reset, imem_ack=1 always, id_ready=1 -> imem_addr 0,4,8..; if_pc 0 one cycle after
//     first push, then 4,8,... every cycle; q_count holds at 1.
//   2 id_ready=0, ack=1 -> 4 pushes (PC 0..C), q_count=4, imem_req=0, imem_addr holds 0x10;
//     release id_ready -> pops 0,4,8,C in order, req reasserts the cycle count<4.
//   3 Queue holding 3 entries, redirect=1, redirect_pc=0x103 -> next cycle q_count=0,
//     if_valid=0, imem_addr=0x100; first new if_pc=0x100.
//   4 ack toggled 1,0,0,1 with id_ready=1 -> imem_addr held during ack=0; if_pc sequence
//     contiguous (0,4), no duplicate or skipped entries.
//   5 RESET_PC=32'hFFFF_FFF8, ack=1 -> pushed PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6 reset asserted with q_count=2 and redirect=1 same cycle -> fetch_pc=RESET_PC,
//     q_count=0, imem_req=0 and if_valid=0 while reset high.

Source files
------------

// File: rtl/pipe_ifetch_queue.sv
// Instruction-fetch initiator with a small prefetch FIFO.
// Owns the fetch PC, requests one word per cycle from instruction memory while
// there is room, and presents buffered {pc, inst} pairs to the ID stage.
// A taken branch (redirect) flushes the FIFO and restarts fetch at the new PC.
//
// Handshakes: a transfer happens on a rising edge where both sides agree in
// that cycle. Memory side: push when imem_req && imem_ack; imem_addr stays put
// while imem_req && !imem_ack, and imem_ack with imem_req low is ignored.
// ID side: pop when if_valid && id_ready; if_inst/if_pc are held while
// if_valid && !id_ready, and id_ready with if_valid low is ignored.
module pipe_ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_inst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     if_valid,
  output logic [31:0]              if_inst,
  output logic [31:0]              if_pc,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          push;
  logic          pop;

  // Low address bits of a redirect target are dropped: fetch is word aligned.
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake qualifiers and FIFO head. Fullness looks only at the registered
  // count, so a pop in the same cycle never frees a slot for a push.
  always_comb begin
    imem_req  = !reset && !redirect && (count != FULL);
    if_valid  = !reset && !redirect && (count != '0);
    imem_addr = fetch_pc;
    if_inst   = inst_mem[rd_ptr];
    if_pc     = pc_mem[rd_ptr];
    push      = imem_req && imem_ack;
    pop       = if_valid && id_ready;
    q_count   = count;
  end

  // Fetch PC, pointers and occupancy; reset beats redirect beats normal flow.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_inst;
    end
  end

endmodule
